// File: rtl/ps2_kbd_pkg.sv
// Shared types, PS/2 set-2 constants and the scan-code to ASCII mapping.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_FE = 8'hFE;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Keyboard status / ack bytes that never form a key event.
  function automatic logic is_status_byte(input logic [7:0] code);
    return (code == SC_AA) || (code == SC_FA) || (code == SC_EE) ||
           (code == SC_FC) || (code == SC_FE) || (code == 8'h00) ||
           (code == 8'hFF);
  endfunction

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       upper);
    logic [7:0] a;
    logic       letter;
    a = '0;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = '0;
    endcase
    letter = (a >= 8'h61) && (a <= 8'h7A);
    if (upper && letter) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit for full/empty.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 prefix parser with modifier tracking, ASCII mapping and event FIFO.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int unsigned CW = $clog2(PAUSE_SKIP + 1);

  ps2_state_t  state;
  ps2_state_t  state_nxt;
  logic [CW-1:0] skip_cnt;

  logic        ev_push;
  logic        ev_ext;
  logic        ev_rel;
  logic [7:0]  ev_ascii;

  logic        lshift;
  logic        rshift;
  logic        caps_held;

  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic [17:0] head;

  assign shift_held = lshift | rshift;
  assign key_valid  = !fifo_empty;
  assign pop        = key_valid && key_ready;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; only a received byte moves the FSM.
  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if      (scan_code == SC_E0) state_nxt = ST_EXT;
          else if (scan_code == SC_F0) state_nxt = ST_BRK;
          else if (scan_code == SC_E1) state_nxt = ST_SKIP;
        end
        ST_EXT: begin
          if      (scan_code == SC_F0) state_nxt = ST_EXT_BRK;
          else if (scan_code != SC_E0) state_nxt = ST_IDLE;
        end
        ST_BRK: begin
          if (scan_code != SC_F0) state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: state_nxt = ST_IDLE;
        ST_SKIP: begin
          if (skip_cnt <= CW'(1)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Event generation from the byte that completes a key sequence.
  always_comb begin
    ev_push  = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_ascii = '0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code != SC_E0 && scan_code != SC_F0 && scan_code != SC_E1 &&
              !is_status_byte(scan_code)) begin
            ev_push  = 1'b1;
            ev_ascii = scan_to_ascii(scan_code, shift_held ^ caps_lock);
          end
        end
        ST_EXT: begin
          if (scan_code != SC_F0 && scan_code != SC_E0 &&
              scan_code != SC_LSHIFT && scan_code != SC_RSHIFT) begin
            ev_push = 1'b1;
            ev_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          if (scan_code != SC_F0) begin
            ev_push = 1'b1;
            ev_rel  = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          if (scan_code != SC_LSHIFT && scan_code != SC_RSHIFT) begin
            ev_push = 1'b1;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pause-sequence byte counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      skip_cnt <= '0;
    end else if (scan_valid) begin
      if (state == ST_IDLE && scan_code == SC_E1) skip_cnt <= CW'(PAUSE_SKIP);
      else if (state == ST_SKIP && skip_cnt != '0) skip_cnt <= skip_cnt - 1'b1;
    end
  end

  // Shift/caps tracking; caps_held suppresses re-toggling on typematic repeat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (ev_push && !ev_ext) begin
      if (scan_code == SC_LSHIFT) lshift <= !ev_rel;
      if (scan_code == SC_RSHIFT) rshift <= !ev_rel;
      if (scan_code == SC_CAPS) begin
        caps_held <= !ev_rel;
        if (!ev_rel && !caps_held) caps_lock <= !caps_lock;
      end
    end
  end

  // Sticky overflow on a push that the FIFO cannot take.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                          overflow <= 1'b0;
    else if (ev_push && fifo_full && !pop) overflow <= 1'b1;
  end

  ps2_event_fifo #(
    .WIDTH (18),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (ev_push),
    .wr_data ({ev_ext, ev_rel, scan_code, ev_ascii}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields are forced to zero while the FIFO is empty.
  always_comb begin
    key_ext     = 1'b0;
    key_release = 1'b0;
    key_code    = '0;
    key_ascii   = '0;
    if (key_valid) begin
      key_ext     = head[17];
      key_release = head[16];
      key_code    = head[15:8];
      key_ascii   = head[7:0];
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed-vector bench with an expected-event queue and a decoupled monitor.
module tb_ps2_scancode_decoder;

  logic       clock;
  logic       resetn;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_ready;
  logic       shift_held;
  logic       caps_lock;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q [$];

  ps2_scancode_decoder #(
    .FIFO_DEPTH (4),
    .PAUSE_SKIP (7)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_ascii   (key_ascii),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .shift_held  (shift_held),
    .caps_lock   (caps_lock),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clock);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel,
                           input logic [7:0] ascii);
    exp_q.push_back({ext, rel, code, ascii});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head is compared against the oldest expectation.
  always @(negedge clock) begin
    #2;
    if (resetn && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got=%h want=none",
                 {key_ext, key_release, key_code, key_ascii});
      end else begin
        check("event", {14'd0, key_ext, key_release, key_code, key_ascii}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    resetn     = 1'b0;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    key_ready  = 1'b0;
    #2;
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    check("reset_flags", {overflow, caps_lock, shift_held}, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // 1) single make, show-ahead latency
    @(negedge clock);
    scan_code = 8'h1C; scan_valid = 1'b1;
    expect_ev(8'h1C, 0, 0, 8'h61);
    #1 check("lat_before", key_valid, 0);
    @(negedge clock);
    scan_valid = 1'b0;
    #1 check("lat_after", key_valid, 1);
    check("head_code", key_code, 8'h1C);
    @(negedge clock);
    key_ready = 1'b1;
    drain("drain1");

    // 2) shift modifier
    send(8'h12); expect_ev(8'h12, 0, 0, 8'h00);
    check("shift_on", shift_held, 1);
    send(8'h1C); expect_ev(8'h1C, 0, 0, 8'h41);
    send(8'hF0); send(8'h1C); expect_ev(8'h1C, 0, 1, 8'h00);
    check("shift_mid", shift_held, 1);
    send(8'hF0); send(8'h12); expect_ev(8'h12, 0, 1, 8'h00);
    check("shift_off", shift_held, 0);
    drain("drain2");

    // 3) extended break, fake shift
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(8'h75, 1, 1, 8'h00);
    send(8'hE0); send(8'h12);
    check("fake_shift", shift_held, 0);
    drain("drain3");

    // 4) caps lock with typematic repeat, pause sequence
    send(8'h58); expect_ev(8'h58, 0, 0, 8'h00);
    send(8'h58); expect_ev(8'h58, 0, 0, 8'h00);
    send(8'hF0); send(8'h58); expect_ev(8'h58, 0, 1, 8'h00);
    check("caps_once", caps_lock, 1);
    send(8'h1C); expect_ev(8'h1C, 0, 0, 8'h41);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C); expect_ev(8'h1C, 0, 0, 8'h41);
    send(8'h16); expect_ev(8'h16, 0, 0, 8'h31);
    drain("drain4");

    // 5) overflow and push+pop at full
    @(negedge clock); key_ready = 1'b0;
    send(8'h15); expect_ev(8'h15, 0, 0, 8'h51);
    send(8'h1D); expect_ev(8'h1D, 0, 0, 8'h57);
    send(8'h24); expect_ev(8'h24, 0, 0, 8'h45);
    send(8'h2D); expect_ev(8'h2D, 0, 0, 8'h52);
    check("pre_ovf", overflow, 0);
    send(8'h2C);
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 8'h15);
    @(negedge clock); key_ready = 1'b1;
    drain("drain5a");
    @(negedge clock); key_ready = 1'b0;
    send(8'h1C); expect_ev(8'h1C, 0, 0, 8'h41);
    send(8'h32); expect_ev(8'h32, 0, 0, 8'h42);
    send(8'h21); expect_ev(8'h21, 0, 0, 8'h43);
    send(8'h23); expect_ev(8'h23, 0, 0, 8'h44);
    @(negedge clock);
    key_ready = 1'b1; scan_code = 8'h2B; scan_valid = 1'b1;
    expect_ev(8'h2B, 0, 0, 8'h46);
    @(negedge clock);
    scan_valid = 1'b0;
    drain("drain5b");

    // 6) async reset mid-sequence
    send(8'hE0); send(8'hF0);
    @(negedge clock);
    #3 resetn = 1'b0;
    #1;
    check("rst_flags", {overflow, caps_lock, shift_held}, 0);
    check("rst_valid", key_valid, 0);
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    send(8'h1C); expect_ev(8'h1C, 0, 0, 8'h61);
    drain("drain6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
